// File: rtl/axi_lite_mem_slave_pkg.sv
// axi_lite_mem_slave_pkg: shared AXI response codes, FSM state types and address decode helper.
package axi_pkg;
    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input logic [32:0] bytes);
        return (addr >= base) && ({1'b0, addr - base} < bytes);
    endfunction
endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// axi_lite_mem_slave_if: AXI4-Lite AR/R/AW/W/B channel bundle with master and slave views.
interface axi_lite_mem_slave_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
    modport master (
        output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_lite_mem_slave_bram_bytewe.sv
// bram_bytewe: simple dual-port RAM, synchronous read, byte-enabled write, read-first on collision.
module bram_bytewe #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wbe
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
        for (int i = 0; i < 4; i++)
            if (i_we && i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder backed by a byte-strobed word RAM.
// Define AXI_SLAVE_WAIT_STATES_EN to insert RESP_DELAY cycles before rvalid and bvalid.
module axi_lite_mem_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH      = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          RESP_DELAY = 0
) (
    input logic                  clk,
    input logic                  rstn,
    axi_lite_mem_slave_if.slave  s_axi
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] BYTES = 33'(DEPTH) * 33'd4;
    rd_state_t     r_rstate;
    wr_state_t     r_wstate;
    logic          r_arready, r_rvalid, r_ar_ok, r_rd_issued;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [AW-1:0] r_raddr;
    logic          r_awready, r_wready, r_bvalid, r_aw_ok;
    logic [1:0]    r_bresp;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [31:0]   w_ar_off, w_aw_off, w_ram_rdata;
    logic          w_ar_hs, w_aw_hs, w_w_hs, w_commit, w_re, w_we;
    logic          w_rd_done, w_wr_done, w_unused;
`ifdef AXI_SLAVE_WAIT_STATES_EN
    localparam int CW = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
    logic [CW-1:0] r_rcnt, r_wcnt;
    assign w_rd_done = (r_rcnt == '0);
    assign w_wr_done = (r_wcnt == '0);
    assign w_unused  = ^{s_axi.axi_arprot, s_axi.axi_awprot, w_ar_off, w_aw_off};
`else
    assign w_rd_done = 1'b1;
    assign w_wr_done = 1'b1;
    assign w_unused  = ^{s_axi.axi_arprot, s_axi.axi_awprot, w_ar_off, w_aw_off, 32'(RESP_DELAY)};
`endif
    assign w_ar_off = s_axi.axi_araddr - BASE_ADDR;
    assign w_aw_off = s_axi.axi_awaddr - BASE_ADDR;
    assign w_ar_hs  = s_axi.axi_arvalid && r_arready;
    assign w_aw_hs  = s_axi.axi_awvalid && r_awready;
    assign w_w_hs   = s_axi.axi_wvalid && r_wready;
    // Both readies low outside W_RESP means address and data are both held: commit phase.
    assign w_commit = (r_wstate != W_RESP) && !r_awready && !r_wready;
    assign w_re     = (r_rstate == R_READ) && !r_rd_issued && r_ar_ok;
    assign w_we     = w_commit && w_wr_done && r_aw_ok;
    bram_bytewe #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_re    (w_re),
        .i_raddr (r_raddr),
        .o_rdata (w_ram_rdata),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (r_wdata),
        .i_wbe   (r_wstrb)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b1;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= AXI_OKAY;
            r_raddr     <= '0;
            r_ar_ok     <= 1'b0;
            r_rd_issued <= 1'b0;
`ifdef AXI_SLAVE_WAIT_STATES_EN
            r_rcnt      <= '0;
`endif
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_raddr     <= w_ar_off[AW+1:2];
                    r_ar_ok     <= addr_in_range(s_axi.axi_araddr, BASE_ADDR, BYTES);
                    r_arready   <= 1'b0;
                    r_rd_issued <= 1'b0;
                    r_rstate    <= R_READ;
`ifdef AXI_SLAVE_WAIT_STATES_EN
                    r_rcnt      <= CW'(RESP_DELAY);
`endif
                end
                R_READ: if (!r_rd_issued) r_rd_issued <= 1'b1;
                else if (w_rd_done) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= r_ar_ok ? w_ram_rdata : 32'h0;
                    r_rresp  <= r_ar_ok ? AXI_OKAY : AXI_DECERR;
                    r_rstate <= R_RESP;
                end
`ifdef AXI_SLAVE_WAIT_STATES_EN
                else r_rcnt <= r_rcnt - 1'b1;
`endif
                R_RESP: if (s_axi.axi_rready) begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_rstate  <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_OKAY;
            r_waddr   <= '0;
            r_aw_ok   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
`ifdef AXI_SLAVE_WAIT_STATES_EN
            r_wcnt    <= '0;
`endif
        end else if (r_wstate == W_RESP) begin
            if (s_axi.axi_bready) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
                r_wstate  <= W_IDLE;
            end
        end else if (w_commit) begin
            if (w_wr_done) begin
                r_bvalid <= 1'b1;
                r_bresp  <= r_aw_ok ? AXI_OKAY : AXI_DECERR;
                r_wstate <= W_RESP;
            end
`ifdef AXI_SLAVE_WAIT_STATES_EN
            else r_wcnt <= r_wcnt - 1'b1;
`endif
        end else begin
            if (w_aw_hs) begin
                r_waddr   <= w_aw_off[AW+1:2];
                r_aw_ok   <= addr_in_range(s_axi.axi_awaddr, BASE_ADDR, BYTES);
                r_awready <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata  <= s_axi.axi_wdata;
                r_wstrb  <= s_axi.axi_wstrb;
                r_wready <= 1'b0;
            end
            r_wstate <= (!r_awready || w_aw_hs) ? W_HAVE_A : (!r_wready || w_w_hs) ? W_HAVE_D : W_IDLE;
`ifdef AXI_SLAVE_WAIT_STATES_EN
            r_wcnt   <= CW'(RESP_DELAY);
`endif
        end
    end
    assign s_axi.axi_arready = r_arready;
    assign s_axi.axi_rvalid  = r_rvalid;
    assign s_axi.axi_rdata   = r_rdata;
    assign s_axi.axi_rresp   = r_rresp;
    assign s_axi.axi_awready = r_awready;
    assign s_axi.axi_wready  = r_wready;
    assign s_axi.axi_bvalid  = r_bvalid;
    assign s_axi.axi_bresp   = r_bresp;
endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
AXI4-Lite responder (slave) that terminates the core's data-memory bus and backs it with an on-chip word-addressed RAM with byte strobes. It sits between the core's mem-stage AXI master and the BRAM, as the far end of the same five channels (AR, R, AW, W, B). Read and write paths are independent FSMs sharing one dual-port RAM.

Parameters:
DEPTH, 4096, number of 32-bit words; legal byte address range is 0 .. DEPTH*4-1
BASE_ADDR, 32'h0, byte address mapped to word 0
RESP_DELAY, 0, extra cycles before rvalid/bvalid assert (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
axi_araddr  in  32  read address
axi_arvalid  in  1  read address valid
axi_arready  out  1  read address ready
axi_arprot  in  3  ignored
axi_rdata  out  32  read data
axi_rresp  out  2  read response
axi_rvalid  out  1  read data valid
axi_rready  in  1  read data ready
axi_awaddr  in  32  write address
axi_awvalid  in  1  write address valid
axi_awready  out  1  write address ready
axi_awprot  in  3  ignored
axi_wdata  in  32  write data
axi_wstrb  in  4  byte strobes, bit i enables wdata[8i+7:8i]
axi_wvalid  in  1  write data valid
axi_wready  out  1  write data ready
axi_bresp  out  2  write response
axi_bvalid  out  1  write response valid
axi_bready  in  1  write response ready

Behaviour:
- Reset (rstn=0, asynchronous): arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=OKAY, bresp=OKAY; both FSMs go to IDLE. RAM contents are not cleared. Reset asserted mid-transaction drops the transaction; no partial response is issued.
- Address decode: off = addr - BASE_ADDR; word index = off[31:2]; addr[1:0] ignored (no misalignment error). The address is in range iff BASE_ADDR <= addr and off < DEPTH*4.
- Read FSM: R_IDLE -> R_READ -> R_RESP.
  - R_IDLE: arready=1. The handshake is arvalid&&arready. It latches araddr, drops arready and moves to R_READ.
  - R_READ: one RAM read cycle (synchronous read). rvalid rises on the next edge. Minimum latency is AR handshake edge to rvalid high = 2 cycles.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rvalid&&rready. On that handshake: rvalid=0, arready=1, back to R_IDLE. No back-to-back overlap; one outstanding read.
  - Out of range: rresp=DECERR (2'b11), rdata=0, and the RAM is not read.
- Write FSM: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: awready=1, wready=1.
  - AW and W are accepted independently, in either order or in the same cycle.
  - AW only -> W_HAVE_A, with awready=0. W only -> W_HAVE_D, with wready=0.
  - Both captured -> RAM write on the following edge -> W_RESP.
  - W_RESP: bvalid=1, held until bvalid&&bready. On that handshake: bvalid=0, awready=wready=1, back to W_IDLE.
  - Strobes: only bytes with wstrb[i]=1 change. wstrb=0 is a legal no-op write that still responds OKAY.
  - Out of range: bresp=DECERR and no RAM write.
- Same-word collision: when a read RAM access and a write RAM commit fall in the same cycle, the read returns the old data (read-first). The next read sees the new data.
- No ready signal depends combinationally on any valid signal. All outputs are registered.

Optional Feature:
- Macro: AXI_SLAVE_WAIT_STATES_EN.
- Defined: a per-FSM down-counter (width $clog2(RESP_DELAY+1)) inserts RESP_DELAY idle cycles before rvalid and before bvalid. The counter is loaded on entry to R_READ or to the write commit. Reset clears the counters.
- Undefined: no counters exist, RESP_DELAY is unused, and latency is as above.
- Purpose: exercises master stall paths.

Decomposition:
- Shared package axi_pkg holds:
  - resp constants: AXI_OKAY=2'b00, AXI_SLVERR=2'b10, AXI_DECERR=2'b11;
  - enums rd_state_t {R_IDLE,R_READ,R_RESP} and wr_state_t {W_IDLE,W_HAVE_A,W_HAVE_D,W_RESP}.
- One sub-module, bram_bytewe: a simple dual-port RAM with a synchronous read port, a write port with 4-bit byte-enables, and read-first collision behaviour. It is inferable as BRAM.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=4'hF and AW/W in the same cycle, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF, rresp=OKAY, rvalid two cycles after the AR handshake.
- W presented 3 cycles before AW (wdata=0x11223344, wstrb=4'b0101, address 0x10 holding 0xDEADBEEF) -> the following read returns 0xDE22BE44; exactly one bvalid pulse.
- Read address DEPTH*4 -> rresp=DECERR, rdata=0. Write to the same address -> bresp=DECERR, and memory is unchanged (read back word 0 is unchanged).
- Hold rready=0 for 5 cycles after rvalid -> rvalid and rdata stay stable and arready stays 0 throughout. bready=0 behaves likewise for bvalid/bresp.
- Same-cycle write commit and read of 0x20 (old value 0, new value 0x5) -> the read returns 0 and a subsequent read returns 0x5.
- Deassert rstn while in W_HAVE_A -> immediately bvalid=0 and awready=wready=1; after release, a new write completes normally. With AXI_SLAVE_WAIT_STATES_EN and RESP_DELAY=3, read latency is 5 cycles.
